// File: rtl/bce_pred_pipe_if.sv
// bce_pred_pipe_if: request/result/statistics bundle between decode, the branch unit and fetch redirect
interface bce_pred_pipe_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [3:0]        in_bf;
  logic [PC_W-1:0]   in_pc;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic              out_is_branch;
  logic              out_taken;
  logic              out_pred;
  logic              out_mispredict;
  logic [PC_W-1:0]   out_pc;
  logic              stat_clr;
  logic [CNT_W-1:0]  stat_branches;
  logic [CNT_W-1:0]  stat_mispred;
  modport master (
    output in_valid, in_a, in_b, in_bf, in_pc, flush, out_ready, stat_clr,
    input  in_ready, out_valid, out_is_branch, out_taken, out_pred, out_mispredict, out_pc,
           stat_branches, stat_mispred
  );
  modport slave (
    input  in_valid, in_a, in_b, in_bf, in_pc, flush, out_ready, stat_clr,
    output in_ready, out_valid, out_is_branch, out_taken, out_pred, out_mispredict, out_pc,
           stat_branches, stat_mispred
  );
endinterface

// File: rtl/bce_pred_pipe.sv
// bce_pred_pipe: one-stage branch condition evaluator with 2-bit saturating PHT predictor and mispredict stats
module bce_pred_pipe #(
  parameter int DATA_W    = 32,
  parameter int PC_W      = 32,
  parameter int PHT_IDX_W = 6,
  parameter int CNT_W     = 16
) (
  input logic            clk,
  input logic            reset,
  bce_pred_pipe_if.slave bus
);
  localparam int N = 1 << PHT_IDX_W;
  logic [1:0]           pht [N];
  logic                 lt, z, eq, is_br, taken, capture, retire, upd, pred;
  logic [PHT_IDX_W-1:0] idx_in, idx_out;
  logic [1:0]           cnt_nxt, cnt_in;
  // decode the branch, resolve the handshake and look up the prediction, bypassing a same-cycle retire update
  always_comb begin
    lt           = bus.in_a[DATA_W-1];
    z            = bus.in_a == '0;
    eq           = bus.in_a == bus.in_b;
    is_br        = bus.in_bf[3] | (bus.in_bf[3:1] == 3'b001);
    taken        = bus.in_bf[3] ? bus.in_bf[1] ^ (bus.in_bf[2] ? (lt | z) : eq)
                                : is_br & (bus.in_bf[0] ^ lt);
    bus.in_ready = (~bus.out_valid | bus.out_ready) & ~bus.flush;
    capture      = bus.in_valid & bus.in_ready;
    retire       = bus.out_valid & bus.out_ready & ~bus.flush;
    upd          = retire & bus.out_is_branch;
    idx_in       = bus.in_pc[PHT_IDX_W+1:2];
    idx_out      = bus.out_pc[PHT_IDX_W+1:2];
    cnt_nxt      = bus.out_taken ? pht[idx_out] + {1'b0, ~&pht[idx_out]}
                                 : pht[idx_out] - {1'b0, |pht[idx_out]};
    cnt_in       = (upd && idx_out == idx_in) ? cnt_nxt : pht[idx_in];
    pred         = is_br & cnt_in[1];
  end
  assign bus.out_mispredict = bus.out_is_branch & (bus.out_taken ^ bus.out_pred);
  // result register: flush kills it, capture loads it, retire without a new capture empties it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.out_valid     <= 1'b0;
      bus.out_is_branch <= 1'b0;
      bus.out_taken     <= 1'b0;
      bus.out_pred      <= 1'b0;
      bus.out_pc        <= '0;
    end else begin
      bus.out_valid <= bus.flush ? 1'b0 : capture ? 1'b1 : retire ? 1'b0 : bus.out_valid;
      if (capture) begin
        bus.out_is_branch <= is_br;
        bus.out_taken     <= taken;
        bus.out_pred      <= pred;
        bus.out_pc        <= bus.in_pc;
      end
    end
  end
  // pattern history table trains on retired branches only; reset leaves every entry weakly not-taken
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) pht[i] <= 2'b01;
    end else if (upd) begin
      pht[idx_out] <= cnt_nxt;
    end
  end
  // saturating retire statistics; clear beats a simultaneous increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.stat_branches <= '0;
      bus.stat_mispred  <= '0;
    end else if (bus.stat_clr) begin
      bus.stat_branches <= '0;
      bus.stat_mispred  <= '0;
    end else if (upd) begin
      bus.stat_branches <= bus.stat_branches + {{(CNT_W-1){1'b0}}, ~&bus.stat_branches};
      bus.stat_mispred  <= bus.stat_mispred + {{(CNT_W-1){1'b0}}, bus.out_mispredict & ~&bus.stat_mispred};
    end
  end
endmodule
